// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared hazard-control definitions: opcodes, forwarding selects, FSM states, stage record.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pipe_hazard_ctrl_pkg;

  // RV32I major opcodes, bits [6:2] of the instruction word
  localparam logic [4:0] OP_R       = 5'b01100;
  localparam logic [4:0] OP_I_ARITH = 5'b00100;
  localparam logic [4:0] OP_I_LOAD  = 5'b00000;
  localparam logic [4:0] OP_S       = 5'b01000;
  localparam logic [4:0] OP_B       = 5'b11000;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_JALR    = 5'b11001;

  // X-stage operand source selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  // Memory wait FSM states
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Per-stage instruction record; an invalid record is all zeros
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       wen;
    logic       is_load;
    logic       is_mem;
    logic       is_jump;
  } stage_t;

  // Operand source for one X-stage register read. M wins over W; a load in
  // M has no data yet, so it never forwards (the load-use stall covers it).
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input stage_t    m,
                                         input stage_t    w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != 5'd0) begin
      if (m.valid && m.wen && !m.is_load && (m.rd == rs)) begin
        sel = FWD_M;
      end else if (w.valid && w.wen && (w.rd == rs)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_decode.sv
// Per-instruction hazard decode: register fields, operand usage and write/memory class.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the result is registered.
module hazard_decode
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        wen,
  output logic        is_load,
  output logic        is_mem,
  output logic        is_jump
);

  logic [4:0] opc;
  logic       unused_bits;

  assign opc         = inst[6:2];
  assign rd          = inst[11:7];
  assign rs1         = inst[19:15];
  assign rs2         = inst[24:20];
  // Function and size fields do not affect hazards
  assign unused_bits = ^{inst[31:25], inst[14:12], inst[1:0]};

  // Classify the opcode; a write to x0 is never a real write
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    wen      = 1'b0;
    is_load  = 1'b0;
    is_mem   = 1'b0;
    is_jump  = 1'b0;
    case (opc)
      OP_R:       begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; wen = 1'b1; end
      OP_I_ARITH: begin uses_rs1 = 1'b1; wen = 1'b1; end
      OP_I_LOAD:  begin uses_rs1 = 1'b1; wen = 1'b1; is_load = 1'b1; is_mem = 1'b1; end
      OP_S:       begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_mem = 1'b1; end
      OP_B:       begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_JAL:     begin wen = 1'b1; is_jump = 1'b1; end
      OP_JALR:    begin uses_rs1 = 1'b1; wen = 1'b1; is_jump = 1'b1; end
      default:    begin end
    endcase
    if (rd == 5'd0) begin
      wen = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the F->X->M->W pipeline: holds, bubbles, flushes, forwarding.
// Latency: controls are combinational from the X/M/W records; records advance one stage per cycle.
// Backpressure: dmem_ready low in M freezes PC, F/X, X/M, M/W for at most WAIT_MAX cycles.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_F,
  input  logic        inst_F_valid,
  input  logic        br_taken_X,
  input  logic        dmem_ready,
  output logic        pc_hold,
  output logic        f_hold,
  output logic        x_bubble,
  output logic        f_flush,
  output logic        mw_hold,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_err
);

  stage_t           x_q, m_q, w_q, x_next;
  logic [0:0]       state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             mem_err_q;

  logic [4:0] f_rd, f_rs1, f_rs2;
  logic       f_uses_rs1, f_uses_rs2, f_wen, f_is_load, f_is_mem, f_is_jump;

  logic mem_pend, timeout, hold_c, redirect, load_use, bubble;
  logic unused_w;

  hazard_decode u_dec_f (
    .inst     (inst_F),
    .rd       (f_rd),
    .rs1      (f_rs1),
    .rs2      (f_rs2),
    .uses_rs1 (f_uses_rs1),
    .uses_rs2 (f_uses_rs2),
    .wen      (f_wen),
    .is_load  (f_is_load),
    .is_mem   (f_is_mem),
    .is_jump  (f_is_jump)
  );

  // W only needs its write-back identity for forwarding
  assign unused_w = ^{w_q.rs1, w_q.rs2, w_q.is_load, w_q.is_mem, w_q.is_jump};

  // Stall arbitration: memory wait > redirect > load-use
  always_comb begin
    mem_pend = m_q.valid & m_q.is_mem & ~dmem_ready;
    timeout  = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(WAIT_MAX));
    hold_c   = mem_pend & ~timeout;
    // rst_n gate keeps f_flush low while in reset even if br_taken_X is high
    redirect = rst_n & ~hold_c & (br_taken_X | (x_q.valid & x_q.is_jump));
    load_use = x_q.valid & x_q.is_load & (x_q.rd != 5'd0) & inst_F_valid &
               ((f_uses_rs1 & (f_rs1 == x_q.rd)) | (f_uses_rs2 & (f_rs2 == x_q.rd)));
    bubble   = load_use & ~hold_c & ~redirect;
  end

  // Next X record: decoded inst_F, or an empty slot for bubble/flush/no instruction
  always_comb begin
    x_next = '0;
    if (inst_F_valid && !bubble && !redirect) begin
      x_next.valid   = 1'b1;
      x_next.rd      = f_rd;
      x_next.rs1     = f_rs1;
      x_next.rs2     = f_rs2;
      x_next.wen     = f_wen;
      x_next.is_load = f_is_load;
      x_next.is_mem  = f_is_mem;
      x_next.is_jump = f_is_jump;
    end
  end

  // Stage records shift together unless the memory wait freezes the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else if (!hold_c) begin
      w_q <= m_q;
      m_q <= x_q;
      x_q <= x_next;
    end
  end

  // Memory wait FSM: count held cycles, fall back to RUN on ready or timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else if (hold_c) begin
      state_q    <= ST_WAIT;
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end else begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err_q <= 1'b0;
    end else if (timeout) begin
      mem_err_q <= 1'b1;
    end
  end

  assign pc_hold  = hold_c | bubble;
  assign f_hold   = hold_c;
  assign x_bubble = bubble;
  assign f_flush  = redirect;
  assign mw_hold  = hold_c;
  assign fwd_a    = fwd_sel(x_q.rs1, m_q, w_q);
  assign fwd_b    = fwd_sel(x_q.rs2, m_q, w_q);
  assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expected control vectors.
// Latency: inputs driven at negedge, outputs sampled 1 ns later.
// Backpressure: dmem_ready driven directly per step.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_F;
  logic        inst_F_valid;
  logic        br_taken_X;
  logic        dmem_ready;
  logic        pc_hold, f_hold, x_bubble, f_flush, mw_hold, mem_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [9:0]  outs;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.WAIT_MAX(15), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_F       (inst_F),
    .inst_F_valid (inst_F_valid),
    .br_taken_X   (br_taken_X),
    .dmem_ready   (dmem_ready),
    .pc_hold      (pc_hold),
    .f_hold       (f_hold),
    .x_bubble     (x_bubble),
    .f_flush      (f_flush),
    .mw_hold      (mw_hold),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_hold, f_hold, x_bubble, f_flush, mw_hold, fwd_a, fwd_b, mem_err}
  assign outs = {pc_hold, f_hold, x_bubble, f_flush, mw_hold, fwd_a, fwd_b, mem_err};

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [6:0] f7);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] inst, input logic v,
                      input logic br, input logic rdy, input logic [9:0] exp);
    @(negedge clk);
    inst_F       = inst;
    inst_F_valid = v;
    br_taken_X   = br;
    dmem_ready   = rdy;
    #1;
    chk(tag, outs, exp);
  endtask

  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_ARI  = 7'b0010011;

  logic [31:0] lw_x5, add_x6, add_x3, sub_x4, addi_x0, add_x7, addi_x8a, addi_x8b;
  logic [31:0] add_x9, lw_x10, add_x11, sw_x10;

  initial begin
    lw_x5    = enc_i(OPC_LOAD, 5'd5, 5'd1, 3'b010, 12'd0);
    add_x6   = enc_r(5'd6, 5'd5, 5'd2, 7'b0000000);
    add_x3   = enc_r(5'd3, 5'd1, 5'd2, 7'b0000000);
    sub_x4   = enc_r(5'd4, 5'd3, 5'd3, 7'b0100000);
    addi_x0  = enc_i(OPC_ARI, 5'd0, 5'd0, 3'b000, 12'd1);
    add_x7   = enc_r(5'd7, 5'd0, 5'd0, 7'b0000000);
    addi_x8a = enc_i(OPC_ARI, 5'd8, 5'd0, 3'b000, 12'd1);
    addi_x8b = enc_i(OPC_ARI, 5'd8, 5'd8, 3'b000, 12'd2);
    add_x9   = enc_r(5'd9, 5'd8, 5'd8, 7'b0000000);
    lw_x10   = enc_i(OPC_LOAD, 5'd10, 5'd1, 3'b010, 12'd0);
    add_x11  = enc_r(5'd11, 5'd10, 5'd0, 7'b0000000);
    sw_x10   = enc_s(5'd2, 5'd10);

    rst_n        = 1'b0;
    inst_F       = 32'd0;
    inst_F_valid = 1'b0;
    br_taken_X   = 1'b0;
    dmem_ready   = 1'b1;
    #1;
    chk("reset_outputs", outs, 10'b00000_00_00_0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load-use: lw x5 in X, add x6,x5,x2 in F
    step("lu_idle",      lw_x5,  1'b1, 1'b0, 1'b1, 10'b00000_00_00_0);
    step("lu_stall",     add_x6, 1'b1, 1'b0, 1'b1, 10'b10100_00_00_0);
    step("lu_bubble_x",  add_x6, 1'b1, 1'b0, 1'b1, 10'b00000_00_00_0);
    step("lu_fwd_w",     add_x3, 1'b1, 1'b0, 1'b1, 10'b00000_10_00_0);
    // Back-to-back ALU: add x3 then sub x4,x3,x3
    step("alu_no_dep",   sub_x4, 1'b1, 1'b0, 1'b1, 10'b00000_00_00_0);
    step("alu_fwd_m",    addi_x0, 1'b1, 1'b0, 1'b1, 10'b00000_01_01_0);
    // x0 handling and M-over-W priority
    step("x0_writer",    add_x7, 1'b1, 1'b0, 1'b1, 10'b00000_00_00_0);
    step("x0_reader",    addi_x8a, 1'b1, 1'b0, 1'b1, 10'b00000_00_00_0);
    step("x8_first",     addi_x8b, 1'b1, 1'b0, 1'b1, 10'b00000_00_00_0);
    step("x8_fwd_m",     add_x9, 1'b1, 1'b0, 1'b1, 10'b00000_01_00_0);
    step("x8_m_over_w",  lw_x10, 1'b1, 1'b0, 1'b1, 10'b00000_01_01_0);
    // Taken branch while load-use is also present
    step("br_over_lu",   add_x11, 1'b1, 1'b1, 1'b1, 10'b00010_00_00_0);
    step("br_x_invalid", sw_x10, 1'b1, 1'b0, 1'b1, 10'b00000_00_00_0);
    step("sw_fwd_w",     32'd0,  1'b0, 1'b0, 1'b1, 10'b00000_00_10_0);
    // Memory wait: sw in M, ready low 3 cycles; redirect ignored while held
    step("mw_hold_1",    32'd0,  1'b0, 1'b0, 1'b0, 10'b11001_00_00_0);
    step("mw_hold_br",   32'd0,  1'b0, 1'b1, 1'b0, 10'b11001_00_00_0);
    step("mw_hold_3",    32'd0,  1'b0, 1'b0, 1'b0, 10'b11001_00_00_0);
    step("mw_release",   32'd0,  1'b0, 1'b0, 1'b1, 10'b00000_00_00_0);
    // Timeout: sw reaches M, ready stays low
    step("to_load_sw",   sw_x10, 1'b1, 1'b0, 1'b1, 10'b00000_00_00_0);
    step("to_sw_in_x",   32'd0,  1'b0, 1'b0, 1'b1, 10'b00000_00_00_0);
    for (int i = 0; i < 15; i++) begin
      step("to_held",    32'd0,  1'b0, 1'b0, 1'b0, 10'b11001_00_00_0);
    end
    step("to_release",   32'd0,  1'b0, 1'b0, 1'b0, 10'b00000_00_00_0);
    step("to_err_set",   sw_x10, 1'b1, 1'b0, 1'b1, 10'b00000_00_00_1);
    step("to_err_stick", 32'd0,  1'b0, 1'b0, 1'b1, 10'b00000_00_00_1);
    // Mid-WAIT asynchronous reset
    step("rst_wait_1",   32'd0,  1'b0, 1'b0, 1'b0, 10'b11001_00_00_1);
    step("rst_wait_2",   32'd0,  1'b0, 1'b0, 1'b0, 10'b11001_00_00_1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs, 10'b00000_00_00_0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset",   32'd0,  1'b0, 1'b0, 1'b0, 10'b00000_00_00_0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 4-stage RV32I pipeline (F -> X -> M -> W).
- Tracks the destination register, write-enable and load/store class of the instructions in X, M and W.
- From these it generates PC/stage hold, bubble and flush controls, X-stage operand forwarding selects, and a bounded wait on the data-memory handshake.
- Sits beside the X-stage decode control. The datapath consumes its outputs directly.

Parameters:
- WAIT_MAX, 15: maximum number of cycles a memory access in M may stall before it is force-released.
- CNT_W, 4: width of the wait counter. Must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inst_F  in  32  instruction currently in F (rs1=[19:15], rs2=[24:20], opcode=[6:2])
- inst_F_valid  in  1  inst_F is a real instruction, not a bubble
- br_taken_X  in  1  X-stage branch resolved taken (already qualified with br_eq/br_lt)
- dmem_ready  in  1  data memory has completed the load/store in M
- pc_hold  out  1  PC register keeps its value
- f_hold  out  1  F/X pipeline register keeps its value
- x_bubble  out  1  F/X register loads a NOP instead of inst_F
- f_flush  out  1  instruction in F is discarded (redirect)
- mw_hold  out  1  X/M and M/W registers keep their values
- fwd_a  out  2  X operand A source: 00 regfile, 01 M ALU result, 10 W writeback data
- fwd_b  out  2  X operand B source, same encoding as fwd_a
- mem_err  out  1  sticky: a memory access hit the WAIT_MAX timeout

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All stage-tracking valids clear; FSM goes to RUN; wait_cnt=0; mem_err=0.
  - Every output is 0. fwd_a/fwd_b are 00.
- Stage tracking:
  - Registers for X, M, W: valid, rd[4:0], rs1, rs2, wen, is_load, is_mem.
  - Decode from the opcode: R/I_arith/I_load/JAL/JALR set wen=1; S and B set wen=0. I_load sets is_load and is_mem; S sets is_mem only.
  - rd=0 forces wen=0 internally.
- Advance:
  - When mw_hold=0, the W record takes M and M takes X.
  - X loads the decoded inst_F, unless x_bubble or f_flush is set, in which case X loads valid=0.
  - f_hold=1 keeps X unchanged only when mw_hold=1. A load-use stall instead injects the bubble.
- Load-use hazard:
  - Condition: X.valid & X.is_load & X.rd!=0 & inst_F_valid, and inst_F uses rs1 or rs2 equal to X.rd.
  - rs2 counts as used only for R/S/B; rs1 is unused for JAL.
  - Response: pc_hold=1, x_bubble=1 for exactly 1 cycle. The dependent instruction then reaches X while the load is in W, and fwd selects 10.
- Redirect:
  - When br_taken_X=1 or X holds JAL/JALR: f_flush=1 for 1 cycle, inst_F is killed, and the next X record is invalid.
  - Redirect outranks load-use: pc_hold and x_bubble stay 0 that cycle.
- Forwarding (combinational, for the record in X), evaluated per operand:
  - 01 if M.valid & M.wen & !M.is_load & M.rd==X.rs.
  - Otherwise 10 if W.valid & W.wen & W.rd==X.rs.
  - Otherwise 00.
  - M has priority over W. rs==0 always gives 00.
- Memory wait FSM, states RUN and WAIT:
  - RUN -> WAIT when M.valid & M.is_mem & !dmem_ready. While in that condition: pc_hold=f_hold=mw_hold=1; x_bubble and f_flush are forced to 0; wait_cnt increments.
  - WAIT -> RUN on dmem_ready=1. Holds drop in that same cycle, and wait_cnt clears.
  - WAIT -> RUN also when wait_cnt==WAIT_MAX. mem_err sets, and the access is released as complete.
  - Memory stall outranks redirect and load-use. br_taken_X is ignored while mw_hold=1 and is re-evaluated when the hold releases.
- mem_err clears only on reset.
- Mid-operation reset: an asynchronous reset during WAIT returns the FSM to RUN and drops all holds immediately.

Decomposition:
- Shared package holds the opcode constants (R, I_arith, I_load, S, B, JAL, JALR), the fwd encodings (FWD_RF=00, FWD_M=01, FWD_W=10) and the FSM state encodings. These are shared with the X-stage control and the datapath muxes.
- One sub-module, hazard_decode: combinational per-instruction decode of rd, rs1, rs2, uses_rs1, uses_rs2, wen, is_load, is_mem. It is instantiated for inst_F only; the results are registered into the X record.

Test Plan:
- Load-use:
  - Stimulus: lw x5,0(x1) in X; add x6,x5,x2 in F.
  - Required: pc_hold=1 and x_bubble=1 for 1 cycle. When the add reaches X, fwd_a=10 and fwd_b=00.
- Back-to-back ALU:
  - Stimulus: add x3,x1,x2; then sub x4,x3,x3.
  - Required: with sub in X, fwd_a=fwd_b=01. No stall.
- x0 and priority:
  - Stimulus: addi x0,x0,1 followed by add x7,x0,x0.
  - Required: fwd=00. With addi x8 in W and M both writing x8, a reader of x8 gets fwd=01.
- Taken branch with load-use in F:
  - Stimulus: br_taken_X=1 while the load-use condition is also true.
  - Required: f_flush=1, pc_hold=0, x_bubble=0. The next X record is invalid.
- Memory wait:
  - Stimulus: sw in M, dmem_ready=0 for 3 cycles, then 1.
  - Required: mw_hold=pc_hold=f_hold=1 for exactly 3 cycles; release in the ready cycle; mem_err=0.
- Timeout and reset:
  - Stimulus: dmem_ready held 0 with WAIT_MAX=15.
  - Required: holds release after 15 held cycles and mem_err=1 sticky. Asserting rst_n=0 mid-WAIT clears all outputs asynchronously.
